// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin registered multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL      = 1'b0;
  localparam logic MODE_ROUND_ROBIN = 1'b1;

  // Width of a channel index; never below one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first set request at or after start_i, wrapping.
module rr_priority_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    start_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                any_o
);

  logic [2*CHANNELS-1:0] reqDbl;
  logic [CHANNELS-1:0]   rotReq;
  logic [SEL_W-1:0]      offset;
  logic [SEL_W:0]        idxSum;
  logic                  found;

  // Doubling the vector lets a plain shift act as a rotate toward bit 0.
  always_comb begin
    reqDbl = {req_i, req_i} >> start_i;
    rotReq = reqDbl[CHANNELS-1:0];
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && rotReq[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
    idxSum = {1'b0, start_i} + {1'b0, offset};
    if (idxSum >= (SEL_W+1)'(CHANNELS)) begin
      idxSum = idxSum - (SEL_W+1)'(CHANNELS);
    end
    idx_o   = idxSum[SEL_W-1:0];
    any_o   = found;
    grant_o = '0;
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel registered multiplexer with manual or round-robin selection and
// valid/ready handshaking on every input and on the output.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  output logic [CHANNELS-1:0]         in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_chan,
  input  logic                        out_ready
);

  logic                outValid_q, outValid_d;
  logic [WIDTH-1:0]    outData_q, outData_d;
  logic [SEL_W-1:0]    outChan_q, outChan_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [SEL_W-1:0]    rrStart;
  logic [CHANNELS-1:0] rrGrant;
  logic [SEL_W-1:0]    rrIdx;
  logic                rrAny;

  logic [CHANNELS-1:0] manGrant;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    winIdx;
  logic [WIDTH-1:0]    winData;
  logic                anyGrant;
  logic                loadEn;
  logic                inXfer;

  assign rrStart = SEL_W'(next_idx(int'(ptr_q), CHANNELS));

  rr_priority_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req_i   (in_valid),
    .start_i (rrStart),
    .grant_o (rrGrant),
    .idx_o   (rrIdx),
    .any_o   (rrAny)
  );

  // Out-of-range selects simply match no channel, so no grant is issued.
  always_comb begin
    manGrant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        manGrant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    grant   = (mode == MODE_ROUND_ROBIN) ? rrGrant : manGrant;
    winIdx  = (mode == MODE_ROUND_ROBIN) ? rrIdx : sel;
    winData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        winData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign anyGrant = |grant;
  assign loadEn   = !outValid_q || out_ready;
  assign inXfer   = anyGrant && loadEn && !reset;
  assign in_ready = (reset || !loadEn) ? '0 : grant;

  // Next-state: load on transfer, drain when empty-handed, hold under backpressure.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outChan_d  = outChan_q;
    ptr_d      = ptr_q;
    if (loadEn) begin
      if (anyGrant) begin
        outValid_d = 1'b1;
        outData_d  = winData;
        outChan_d  = winIdx;
      end else begin
        outValid_d = 1'b0;
      end
    end
    if (inXfer && mode == MODE_ROUND_ROBIN) begin
      ptr_d = rrIdx;
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first search.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outChan_q  <= '0;
      ptr_q      <= SEL_W'(CHANNELS - 1);
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outChan_q  <= outChan_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_chan  = outChan_q;

endmodule
